fetch_sequencer: RTL and testbench

Multicycle control FSM that drives the fetch unit and hands fetched instructions to decode. It sequences the reset-vector load, the opcode and optional immediate fetch, and the PC redirect on branch/return. It also handles interrupt entry at instruction boundaries, and presents each complete instruction (IR plus imm) to decode through a valid/ready handshake.

---
 rtl/fetch_sequencer_if.sv | 47 ++++
 rtl/fetch_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the sequencer's fetch-unit controls, the memory
// read bus and the decode handshake. The master modport is the sequencer; the
// slave modport is the fetch/decode side that consumes its controls.
interface fetch_sequencer_if;
    logic [7:0] mem_data;
    logic       decode_ready;
    logic       redirect_valid;
    logic [2:0] redirect_src;
    logic       pc_write;
    logic       ir_write;
    logic       imm_write;
    logic [2:0] pc_src;
    logic [1:0] addr_sel;
    logic       instr_valid;
    logic       instr_long;
    logic       int_ack;

    modport master (
        input  mem_data,
        input  decode_ready,
        input  redirect_valid,
        input  redirect_src,
        output pc_write,
        output ir_write,
        output imm_write,
        output pc_src,
        output addr_sel,
        output instr_valid,
        output instr_long,
        output int_ack
    );

    modport slave (
        output mem_data,
        output decode_ready,
        output redirect_valid,
        output redirect_src,
        input  pc_write,
        input  ir_write,
        input  imm_write,
        input  pc_src,
        input  addr_sel,
        input  instr_valid,
        input  instr_long,
        input  int_ack
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle control FSM for the fetch unit. Sequences the
// reset-vector load, opcode fetch, optional immediate fetch, PC redirects and
// interrupt entry, and offers each complete instruction to decode through a
// valid/ready handshake.
//
// Build option: define FETCH_SEQ_IRQ_EN to build the irq edge detector, the
// pending flag and the S_INT entry state. Without it irq is ignored and
// int_ack is tied low.
module fetch_sequencer #(
    parameter logic [3:0] LONG_OPCODE = 4'hC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              irq,
    fetch_sequencer_if.master bus
);

    // PC mux select codes understood by the fetch unit.
    localparam logic [2:0] PC_SRC_SEQ    = 3'b000;  // PC + 1
    localparam logic [2:0] PC_SRC_IMM    = 3'b001;  // PC + 2, past the immediate
    localparam logic [2:0] PC_SRC_RSTVEC = 3'b100;  // M[0]
`ifdef FETCH_SEQ_IRQ_EN
    localparam logic [2:0] PC_SRC_INTVEC = 3'b101;  // M[1]
`endif

    // Memory address select codes.
    localparam logic [1:0] ADDR_PC     = 2'b00;
    localparam logic [1:0] ADDR_PC_P1  = 2'b01;
    localparam logic [1:0] ADDR_RSTVEC = 2'b10;
`ifdef FETCH_SEQ_IRQ_EN
    localparam logic [1:0] ADDR_INTVEC = 2'b11;
`endif

    typedef enum logic [2:0] {
        S_RST_VEC   = 3'd0,
        S_FETCH     = 3'd1,
        S_FETCH_IMM = 3'd2,
`ifdef FETCH_SEQ_IRQ_EN
        S_ISSUE     = 3'd3,
        S_INT       = 3'd4
`else
        S_ISSUE     = 3'd3
`endif
    } state_t;

    state_t state;
    state_t next_state;
    logic   instr_long_q;
    logic   is_long;
    logic   handshake;

    // Only the opcode nibble decides the instruction length; the low nibble
    // belongs to decode.
    logic [3:0] mem_low_unused;
    assign mem_low_unused = bus.mem_data[3:0];

    assign is_long   = (bus.mem_data[7:4] == LONG_OPCODE);
    assign handshake = (state == S_ISSUE) && bus.decode_ready;

`ifdef FETCH_SEQ_IRQ_EN
    logic irq_prev;
    logic irq_pending;

    // Rising-edge detect on irq; the request is held until S_INT takes it.
    // A fresh edge arriving in the S_INT cycle itself is kept as a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
        end else if (!stall) begin
            irq_prev <= irq;
            if (irq && !irq_prev) begin
                irq_pending <= 1'b1;
            end else if (state == S_INT) begin
                irq_pending <= 1'b0;
            end
        end
    end
`else
    logic irq_unused;
    assign irq_unused = irq;
`endif

    // State register; stall freezes the FSM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST_VEC;
        end else if (!stall) begin
            state <= next_state;
        end
    end

    // Instruction length is decided once in S_FETCH and held through S_ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_long_q <= 1'b0;
        end else if (!stall && (state == S_FETCH)) begin
            instr_long_q <= is_long;
        end
    end

    // Next-state logic: redirect beats interrupt beats normal flow at the
    // handshake, and interrupts are only taken from S_ISSUE (a boundary).
    // NOTE: next_state gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_RST_VEC:   next_state = S_FETCH;
            S_FETCH:     next_state = is_long ? S_FETCH_IMM : S_ISSUE;
            S_FETCH_IMM: next_state = S_ISSUE;
            S_ISSUE: begin
                if (handshake) begin
                    next_state = S_FETCH;
`ifdef FETCH_SEQ_IRQ_EN
                    if (!bus.redirect_valid && irq_pending) begin
                        next_state = S_INT;
                    end
`endif
                end
            end
`ifdef FETCH_SEQ_IRQ_EN
            S_INT:       next_state = S_FETCH;
`endif
            default:     next_state = S_RST_VEC;
        endcase
    end

    // Output decode; write enables and int_ack are masked by stall and by
    // reset, while the selects and instr_valid always follow the state.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.imm_write   = 1'b0;
        bus.int_ack     = 1'b0;
        bus.pc_src      = PC_SRC_SEQ;
        bus.addr_sel    = ADDR_PC;
        bus.instr_valid = 1'b0;
        bus.instr_long  = instr_long_q;
        case (state)
            S_RST_VEC: begin
                bus.addr_sel = ADDR_RSTVEC;
                bus.pc_src   = PC_SRC_RSTVEC;
                bus.pc_write = 1'b1;
            end
            S_FETCH: begin
                bus.addr_sel = ADDR_PC;
                bus.ir_write = 1'b1;
                // A long opcode leaves PC on the opcode so PC+1 addresses imm.
                bus.pc_write = !is_long;
            end
            S_FETCH_IMM: begin
                bus.addr_sel  = ADDR_PC_P1;
                bus.imm_write = 1'b1;
                bus.pc_src    = PC_SRC_IMM;
                bus.pc_write  = 1'b1;
            end
            S_ISSUE: begin
                bus.instr_valid = 1'b1;
                if (handshake && bus.redirect_valid) begin
                    bus.pc_src   = bus.redirect_src;
                    bus.pc_write = 1'b1;
                end
            end
`ifdef FETCH_SEQ_IRQ_EN
            S_INT: begin
                bus.addr_sel = ADDR_INTVEC;
                bus.pc_src   = PC_SRC_INTVEC;
                bus.pc_write = 1'b1;
                bus.int_ack  = 1'b1;
            end
`endif
            default: begin
                bus.pc_src   = PC_SRC_SEQ;
                bus.addr_sel = ADDR_PC;
            end
        endcase
        if (stall || rst) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.imm_write = 1'b0;
            bus.int_ack   = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: drives fetch_sequencer against a small fetch-unit model
// (memory, PC, IR, imm). Expected instructions and interrupt entries are queued
// as stimulus is issued; a monitor pops and compares on every handshake and
// on every int_ack. Works with or without FETCH_SEQ_IRQ_EN.
module tb_fetch_sequencer;

    localparam logic [7:0] PC_BRANCH = 8'h40;
    localparam logic [7:0] PC_STACK  = 8'h50;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic stall = 1'b0;
    logic irq   = 1'b0;

    fetch_sequencer_if bus();

    fetch_sequencer #(.LONG_OPCODE(4'hC)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .irq   (irq),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Fetch-unit model.
    logic [7:0] mem [256];
    logic [7:0] pc  = 8'h00;
    logic [7:0] ir  = 8'h00;
    logic [7:0] imm = 8'h00;
    logic [7:0] addr;

    always_comb begin
        case (bus.addr_sel)
            2'b00:   addr = pc;
            2'b01:   addr = pc + 8'd1;
            2'b10:   addr = 8'h00;
            default: addr = 8'h01;
        endcase
    end

    assign bus.mem_data = mem[addr];

    always @(posedge clk) begin
        if (bus.pc_write) begin
            case (bus.pc_src)
                3'b000:  pc <= pc + 8'd1;
                3'b001:  pc <= pc + 8'd2;
                3'b010:  pc <= PC_BRANCH;
                3'b011:  pc <= PC_STACK;
                3'b100:  pc <= bus.mem_data;
                3'b101:  pc <= bus.mem_data;
                default: pc <= pc;
            endcase
        end
        if (bus.ir_write)  ir  <= bus.mem_data;
        if (bus.imm_write) imm <= bus.mem_data;
    end

    // Scoreboard.
    typedef struct {
        logic       is_int;
        logic [7:0] ir;
        logic [7:0] imm;
        logic       lng;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_instr(input logic [7:0] i, input logic [7:0] m, input logic l,
                              input logic [7:0] p);
        sb.push_back('{is_int: 1'b0, ir: i, imm: m, lng: l, pc: p});
    endtask

    task automatic push_int();
        sb.push_back('{is_int: 1'b1, ir: 8'h00, imm: 8'h00, lng: 1'b0, pc: 8'h00});
    endtask

    // Monitor: samples mid-low-phase, after drivers have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !stall && bus.instr_valid && bus.decode_ready) begin
                check("instr_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("kind_instr", e.is_int, 0);
                    check("ir", ir, e.ir);
                    check("instr_long", bus.instr_long, e.lng);
                    check("pc_at_issue", pc, e.pc);
                    if (e.lng) check("imm", imm, e.imm);
                end
            end
            if (bus.int_ack) begin
                check("int_ack_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("kind_int", e.is_int, 1);
                end
            end
        end
    end

    // what: 0 = ir_write (S_FETCH), 1 = imm_write (S_FETCH_IMM), 2 = instr_valid.
    task automatic wait_for(input int what, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            case (what)
                0:       seen = bus.ir_write;
                1:       seen = bus.imm_write;
                default: seen = bus.instr_valid;
            endcase
        end
        check({name, "_reached"}, seen, 1);
    endtask

    // Waits for the offered instruction with spurious redirect requests
    // outstanding (they must be ignored), holds it for 'hold' cycles, then
    // accepts it with the given redirect.
    task automatic accept(input logic redir, input logic [2:0] src, input int hold);
        bus.decode_ready   = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_src   = 3'b010;
        wait_for(2, "issue");
        repeat (hold) begin
            @(negedge clk);
            #1;
        end
        bus.decode_ready   = 1'b1;
        bus.redirect_valid = redir;
        bus.redirect_src   = src;
        @(posedge clk);
        #1;
        bus.decode_ready   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_src   = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at t=%0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pc0, ir0, imm0;
        int t[4];
        int n;

        bus.decode_ready   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_src   = 3'b000;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h60;
        mem[8'h20] = 8'h15; mem[8'h21] = 8'hC4; mem[8'h22] = 8'h7A;
        mem[8'h23] = 8'h01; mem[8'h24] = 8'h02;
        mem[8'h40] = 8'h33; mem[8'h41] = 8'h24; mem[8'h42] = 8'hC8; mem[8'h43] = 8'h05;
        mem[8'h50] = 8'hC1; mem[8'h51] = 8'h9E;
        mem[8'h52] = 8'h24; mem[8'h53] = 8'hC8; mem[8'h54] = 8'h05;
        mem[8'h60] = 8'h24; mem[8'h61] = 8'hC8; mem[8'h62] = 8'h05;

        // Reset state.
        #1;
        check("rst_pc_write", bus.pc_write, 0);
        check("rst_ir_imm_write", {bus.ir_write, bus.imm_write}, 0);
        check("rst_valid_ack", {bus.instr_valid, bus.int_ack}, 0);
        check("rst_addr_sel", bus.addr_sel, 2'b10);
        check("rst_pc_src", bus.pc_src, 3'b100);

        // Cold start.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cold_pc_edge1", pc, 8'h20);
        @(posedge clk);
        #1;
        check("cold_ir_edge2", ir, 8'h15);
        check("cold_pc_edge2", pc, 8'h21);
        check("cold_valid_edge2", bus.instr_valid, 1);
        check("cold_long_edge2", bus.instr_long, 0);
        push_instr(8'h15, 8'h00, 1'b0, 8'h21);
        accept(1'b0, 3'b000, 0);

        // Long instruction, then branch redirect to PC_BRANCH.
        push_instr(8'hC4, 8'h7A, 1'b1, 8'h23);
        wait_for(1, "fetch_imm_c4");
        check("long_pc_held", pc, 8'h21);
        check("long_ir_loaded", ir, 8'hC4);
        accept(1'b1, 3'b010, 2);

        // Short at branch target, then return redirect to PC_STACK.
        push_instr(8'h33, 8'h00, 1'b0, 8'h41);
        accept(1'b1, 3'b011, 0);

        // irq pulse during the immediate fetch: taken only after the handshake.
        push_instr(8'hC1, 8'h9E, 1'b1, 8'h52);
`ifdef FETCH_SEQ_IRQ_EN
        push_int();
`endif
        wait_for(1, "fetch_imm_c1");
        irq = 1'b1;
        accept(1'b0, 3'b000, 1);

        // irq still high: no second entry.
`ifdef FETCH_SEQ_IRQ_EN
        push_instr(8'h24, 8'h00, 1'b0, 8'h61);
`else
        push_instr(8'h24, 8'h00, 1'b0, 8'h53);
`endif
        accept(1'b0, 3'b000, 0);
        irq = 1'b0;

        // New irq edge plus redirect on the same handshake: redirect first.
`ifdef FETCH_SEQ_IRQ_EN
        push_instr(8'hC8, 8'h05, 1'b1, 8'h63);
`else
        push_instr(8'hC8, 8'h05, 1'b1, 8'h55);
`endif
        wait_for(1, "fetch_imm_c8");
        irq = 1'b1;
        accept(1'b1, 3'b010, 0);

        push_instr(8'h33, 8'h00, 1'b0, 8'h41);
`ifdef FETCH_SEQ_IRQ_EN
        push_int();
`endif
        accept(1'b0, 3'b000, 0);
        irq = 1'b0;

        // Stall for 3 cycles in S_FETCH.
`ifdef FETCH_SEQ_IRQ_EN
        push_instr(8'h24, 8'h00, 1'b0, 8'h61);
`else
        push_instr(8'h24, 8'h00, 1'b0, 8'h42);
`endif
        wait_for(0, "fetch_before_stall");
        stall = 1'b1;
        #1;
        check("stall_pc_write", bus.pc_write, 0);
        check("stall_ir_write", bus.ir_write, 0);
        check("stall_addr_sel", bus.addr_sel, 2'b00);
        pc0 = pc; ir0 = ir; imm0 = imm;
        repeat (3) @(posedge clk);
        #1;
        check("stall_pc_hold", pc, pc0);
        check("stall_ir_hold", ir, ir0);
        check("stall_imm_hold", imm, imm0);
        stall = 1'b0;
        #1;
        check("stall_state_hold", bus.ir_write, 1);

        // Stalled handshake is ignored.
        wait_for(2, "issue_before_stall");
        stall = 1'b1;
        bus.decode_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("stall_ignores_ready", bus.instr_valid, 1);
        stall = 1'b0;
        bus.decode_ready = 1'b0;
        accept(1'b0, 3'b000, 0);

        // Reset while a long instruction is offered: dropped at once.
        wait_for(2, "issue_before_reset");
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.instr_valid, 0);
        check("midrst_pc_write", bus.pc_write, 0);
        check("midrst_addr_sel", bus.addr_sel, 2'b10);
        check("midrst_pc_src", bus.pc_src, 3'b100);

        // Cold restart with decode_ready tied high: throughput 3 long / 2 short.
        push_instr(8'h15, 8'h00, 1'b0, 8'h21);
        push_instr(8'hC4, 8'h7A, 1'b1, 8'h23);
        push_instr(8'h01, 8'h00, 1'b0, 8'h24);
        push_instr(8'h02, 8'h00, 1'b0, 8'h25);
        @(negedge clk);
        bus.decode_ready   = 1'b1;
        bus.redirect_valid = 1'b0;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            #1;
            if (bus.instr_valid) begin
                t[n] = i;
                n++;
            end
        end
        check("tput_count", n, 4);
        if (n == 4) begin
            check("tput_long_cycles", t[1] - t[0], 3);
            check("tput_short_cycles_a", t[2] - t[1], 2);
            check("tput_short_cycles_b", t[3] - t[2], 2);
        end
        @(posedge clk);
        #1;
        bus.decode_ready = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
